// File: rtl/uart_tx_fifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain_pkg
//   Shared UART definitions: frame state encoding and the default bit period.
//   Imported by the TX drain block and its bit timer, and intended to be
//   reused by the matching RX block.
// ---------------------------------------------------------------------------
package uart_tx_fifo_drain_pkg;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // ST_PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage : uart_tx_fifo_drain_pkg

// File: rtl/uart_tx_fifo_drain_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
//   Bit-period counter shared by the UART TX and RX blocks. Counts
//   0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary; never exceeds
//   CLKS_PER_BIT-1.
//
// Ports:
//   clk        in   system clock, posedge
//   reset      in   synchronous, active-high reset
//   clear_i    in   hold the counter at 0 (used while the line is idle)
//   bit_end_o  out  high on the last clock of the current bit period
// ---------------------------------------------------------------------------
module uart_bit_timer
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_end_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_bit_timer

// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
//   8N1 UART transmitter sitting directly behind the TX byte FIFO. Whenever
//   the FIFO is non-empty and the line is idle it pops one byte and sends it
//   LSB first. Carries its own bit-period timer, no external baud tick.
//
// Configuration macro:
//   UART_TX_PARITY_EN  when defined, a parity bit (even, or odd when
//                      PARITY_ODD=1) is sent between the data and stop bits.
//
// Ports:
//   clk           in   system clock, posedge
//   reset         in   synchronous, active-high reset
//   fifo_empty    in   FIFO empty flag
//   fifo_r_data   in   FIFO head word, valid while fifo_empty=0
//   fifo_rd       out  pop strobe, combinational, one cycle per byte
//   tx            out  serial line, registered, idle high
//   tx_busy       out  registered, high while a frame is in progress
//   tx_done_tick  out  pulse on the final clock of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned DBIT         = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Wide enough for data-bit index and stop-bit index.
    localparam int unsigned IDX_W = $clog2(DBIT) + 1;

    uart_state_e      state_q, state_d;
    logic [DBIT-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Counter sits at 0 throughout IDLE, so the start bit gets a full period.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Pop and load on the same edge; start bit appears next cycle.
                if (!fifo_empty && !reset) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_r_data;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^fifo_r_data) ^ 1'(PARITY_ODD);
`endif
                end
            end

            ST_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        idx_d   = '0;
`endif
                    end else begin
                        // Next bit to show is the one that shifts into [0].
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end
            end
`endif

            ST_STOP: begin
                if (bit_end) begin
                    // idx counts stop bits here.
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        tx_done_tick = !reset;
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            // NOTE: the shift register is reset as well, so its contents are
            // deterministic even though they are reloaded on every pop.
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule : uart_tx_fifo_drain
